// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_arbiter: two-port front end that shares one SDRAM controller.
// Define SDRAM_ARB_ROUND_ROBIN_EN for alternating grants; default is fixed priority.
// Revision: 1.0
// ============================================================================
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    p0_valid,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_din,
  input  logic [DATA_WIDTH/8-1:0] p0_wmask,
  output logic [DATA_WIDTH-1:0]   p0_dout,
  output logic                    p0_ready,
  input  logic                    p1_valid,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_din,
  input  logic [DATA_WIDTH/8-1:0] p1_wmask,
  output logic [DATA_WIDTH-1:0]   p1_dout,
  output logic                    p1_ready,
  output logic                    mem_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  input  logic                    mem_ready,
  output logic                    grant
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_start;
  logic                    w_done;
  logic                    w_winner;

  logic                    r_mem_valid;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_din;
  logic [MASK_WIDTH-1:0]   r_mem_wmask;
  logic                    r_grant;
  logic                    r_last_grant;
  logic [DATA_WIDTH-1:0]   r_p0_dout;
  logic [DATA_WIDTH-1:0]   r_p1_dout;
  logic                    r_p0_ready;
  logic                    r_p1_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Under contention hand the bus to whoever did not have it last.
    if (p0_valid && p1_valid) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = ~p0_valid;
    end
`else
    w_winner = ~p0_valid;
`endif
    case (r_state)
      ST_IDLE: begin
        if (p0_valid || p1_valid) begin
          w_start      = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_done       = 1'b1;
          w_state_next = ST_RECOVER;
        end
      end
      ST_RECOVER: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_mem_wmask  <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_p0_dout    <= '0;
      r_p1_dout    <= '0;
      r_p0_ready   <= 1'b0;
      r_p1_ready   <= 1'b0;
    end else begin
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      if (w_start) begin
        r_mem_valid <= 1'b1;
        r_grant     <= w_winner;
        r_mem_addr  <= w_winner ? p1_addr  : p0_addr;
        r_mem_din   <= w_winner ? p1_din   : p0_din;
        r_mem_wmask <= w_winner ? p1_wmask : p0_wmask;
      end
      // Only the owning port's read data register is touched on completion.
      if (w_done) begin
        r_mem_valid  <= 1'b0;
        r_last_grant <= r_grant;
        if (r_grant) begin
          r_p1_dout  <= mem_dout;
          r_p1_ready <= 1'b1;
        end else begin
          r_p0_dout  <= mem_dout;
          r_p0_ready <= 1'b1;
        end
      end
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_wmask = r_mem_wmask;
  assign grant     = r_grant;
  assign p0_dout   = r_p0_dout;
  assign p1_dout   = r_p1_dout;
  assign p0_ready  = r_p0_ready;
  assign p1_ready  = r_p1_ready;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_arbiter: randomized two-requester bench with a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_sdram_arbiter;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          p0_valid, p1_valid;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_din, p1_din, p0_dout, p1_dout;
  logic [MW-1:0] p0_wmask, p1_wmask;
  logic          p0_ready, p1_ready;
  logic          mem_valid, mem_ready, grant;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [MW-1:0] mem_wmask;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_din(p0_din), .p0_wmask(p0_wmask),
    .p0_dout(p0_dout), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_din(p1_din), .p1_wmask(p1_wmask),
    .p1_dout(p1_dout), .p1_ready(p1_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wmask(mem_wmask),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  // Requester-side request registers
  bit            rq_valid [2];
  logic [AW-1:0] rq_addr  [2];
  logic [DW-1:0] rq_din   [2];
  logic [MW-1:0] rq_wmask [2];

  assign p0_valid = rq_valid[0];
  assign p1_valid = rq_valid[1];
  assign p0_addr  = rq_addr[0];
  assign p1_addr  = rq_addr[1];
  assign p0_din   = rq_din[0];
  assign p1_din   = rq_din[1];
  assign p0_wmask = rq_wmask[0];
  assign p1_wmask = rq_wmask[1];

  // Transaction-level model: one outstanding transaction, next arbitration cycle
  bit            m_busy;
  bit            m_owner;
  bit            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [MW-1:0] m_wmask;
  bit            e_grant;
  bit            e_ready [2];
  logic [DW-1:0] e_dout  [2];
  int            cyc;
  int            m_next;

  // Stimulus knobs
  int            ctl_wait;
  int            lat_max;
  int            spur_pct;
  int            req_pct [2];
  bit            auto_req;
  bit            force_en;
  logic [DW-1:0] force_val;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_req(input int p);
    rq_valid[p] = 1'b1;
    rq_addr[p]  = AW'($urandom);
    rq_din[p]   = $urandom;
    rq_wmask[p] = ($urandom_range(0, 1) == 0) ? 4'b0000 : MW'($urandom);
  endtask

  // Effect of the coming clock edge, derived from the arbitration rules
  task automatic predict();
    cyc++;
    e_ready[0] = 1'b0;
    e_ready[1] = 1'b0;
    if (!resetn) begin
      m_busy    = 1'b0;
      m_last    = 1'b1;
      e_grant   = 1'b0;
      e_dout[0] = '0;
      e_dout[1] = '0;
      m_next    = cyc + 1;
    end else if (m_busy) begin
      if (mem_ready) begin
        e_ready[m_owner] = 1'b1;
        e_dout[m_owner]  = mem_dout;
        m_last           = m_owner;
        m_busy           = 1'b0;
        m_next           = cyc + 2;
      end
    end else if (cyc >= m_next && (rq_valid[0] || rq_valid[1])) begin
      if (rq_valid[0] && rq_valid[1]) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        m_owner = !m_last;
`else
        m_owner = 1'b0;
`endif
      end else begin
        m_owner = rq_valid[1];
      end
      e_grant  = m_owner;
      m_busy   = 1'b1;
      m_addr   = rq_addr[m_owner];
      m_din    = rq_din[m_owner];
      m_wmask  = rq_wmask[m_owner];
      ctl_wait = int'($urandom_range(0, lat_max));
    end
  endtask

  task automatic check_outputs();
    check("mem_valid", mem_valid, m_busy);
    check("grant", grant, e_grant);
    check("p0_ready", p0_ready, e_ready[0]);
    check("p1_ready", p1_ready, e_ready[1]);
    check("p0_dout", p0_dout, e_dout[0]);
    check("p1_dout", p1_dout, e_dout[1]);
    if (m_busy) check("mem_req", {mem_addr, mem_din, mem_wmask}, {m_addr, m_din, m_wmask});
    if (!resetn) check("rst_mem_req", {mem_addr, mem_din, mem_wmask}, '0);
  endtask

  task automatic drive();
    if (m_busy) begin
      if (ctl_wait == 0) begin
        mem_ready = 1'b1;
        mem_dout  = force_en ? force_val : $urandom;
      end else begin
        mem_ready = 1'b0;
        ctl_wait--;
      end
    end else begin
      mem_ready = ($urandom_range(0, 99) < spur_pct);
      mem_dout  = $urandom;
    end
    for (int p = 0; p < 2; p++) begin
      if (e_ready[p]) begin
        if (auto_req && $urandom_range(0, 1) == 1) new_req(p);
        else rq_valid[p] = 1'b0;
      end else if (!rq_valid[p] && auto_req && $urandom_range(0, 99) < req_pct[p]) begin
        new_req(p);
      end
    end
  endtask

  task automatic step();
    drive();
    predict();
    @(negedge clk);
    check_outputs();
  endtask

  // Steps until the DUT pulses ready on port p; optionally scrambles idle port 0 inputs
  task automatic run_until_ready(input int p, input bit scramble, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (scramble) begin
        rq_addr[0]  = AW'($urandom);
        rq_din[0]   = $urandom;
        rq_wmask[0] = MW'($urandom);
      end
      step();
      if ((p == 0) ? p0_ready : p1_ready) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    resetn    = 1'b0;
    mem_ready = 1'b0;
    mem_dout  = '0;
    auto_req  = 1'b0;
    spur_pct  = 0;
    lat_max   = 3;
    req_pct[0] = 0;
    req_pct[1] = 0;
    cyc       = 0;
    m_next    = 0;
    m_busy    = 1'b0;
    m_last    = 1'b1;
    ctl_wait  = 0;
    force_en  = 1'b1;
    force_val = 32'hDEADBEEF;
    rq_valid[0] = 1'b1; rq_addr[0] = 25'h0000100; rq_din[0] = 32'h0;         rq_wmask[0] = 4'b0000;
    rq_valid[1] = 1'b1; rq_addr[1] = 25'h1FFFFFC; rq_din[1] = 32'hA5A5_5A5A; rq_wmask[1] = 4'b0011;
    @(negedge clk);

    // Reset held with both requests pending
    repeat (4) step();
    resetn = 1'b1;
    step();
    check("first_valid", mem_valid, 1'b1);
    check("first_grant", grant, 1'b0);
    check("first_addr", mem_addr, 25'h0000100);

    // Single read on port 0, then the pending port 1 write under noisy port 0 inputs
    run_until_ready(0, 1'b0, "p0_read_done");
    check("p0_read_data", p0_dout, 32'hDEADBEEF);
    check("p1_no_ready", p1_ready, 1'b0);
    check("mv_low_after_ready", mem_valid, 1'b0);
    force_en = 1'b0;
    lat_max  = 6;
    run_until_ready(1, 1'b1, "p1_write_done");
    check("p1_write_grant", grant, 1'b1);
    check("mv_low_after_write", mem_valid, 1'b0);

    // Continuous contention
    auto_req   = 1'b1;
    lat_max    = 3;
    req_pct[0] = 100;
    req_pct[1] = 100;
    repeat (400) step();

    // Sparse mixed traffic with stray controller ready pulses
    req_pct[0] = 30;
    req_pct[1] = 50;
    spur_pct   = 20;
    repeat (1500) step();

    // Reset in the middle of a transaction
    auto_req = 1'b0;
    spur_pct = 0;
    lat_max  = 8;
    for (int n = 0; n < 40 && (m_busy || rq_valid[0] || rq_valid[1]); n++) step();
    new_req(0);
    for (int n = 0; n < 3 && !m_busy; n++) step();
    check("midrst_busy", mem_valid, 1'b1);
    resetn      = 1'b0;
    rq_valid[0] = 1'b0;
    rq_valid[1] = 1'b0;
    step();
    check("midrst_valid", mem_valid, 1'b0);
    check("midrst_ready", {p0_ready, p1_ready}, 2'b00);
    resetn = 1'b1;
    step();
    new_req(1);
    run_until_ready(1, 1'b0, "post_rst_p1_done");
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
